// File: rtl/dmem_pkg.sv
// Shared defaults, request/response types and width helpers for the MEM-stage
// data-memory access controller.
package dmem_pkg;

   localparam int DMEM_ADDR_W    = 8;
   localparam int DMEM_DATA_W    = 64;
   localparam int DMEM_RSP_DEPTH = 2;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic [DMEM_DATA_W-1:0] rdata;
   } dmem_rsp_t;

   // Width of a counter that must represent every value 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// First-word-fall-through load-response FIFO: the head word is visible on
// pop_data whenever empty is low, and a pushed word appears the cycle after.
module dmem_rsp_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH  = DMEM_RSP_DEPTH,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int               PTR_W = ptr_w(DEPTH);
   localparam int               CNT_W = cnt_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] slots [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = slots[rd_ptr];

   // NOTE: storage is reset with the pointers so the head word reads zero out of
   // reset; affordable only because the FIFO is a couple of entries deep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_data;
            wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage front end for the dual-port Data_Mem BRAM: registered port A writes,
// registered port B reads, store-to-load forwarding and credit-based load flow control.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int RSP_DEPTH = DMEM_RSP_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dina,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addrb,
   input  logic [DATA_W-1:0] mem_doutb
);

   localparam int CRED_W = cnt_w(RSP_DEPTH);

   typedef struct packed {
      logic              valid;
      logic              hit;
      logic [DATA_W-1:0] data;
   } ld_stage_t;

   logic [CRED_W-1:0] credits;
   logic              lv;
   logic [ADDR_W-1:0] laddr;
   logic [DATA_W-1:0] ldata;
   ld_stage_t         s1;
   ld_stage_t         s2;
   logic              st_acc;
   logic              ld_acc;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;
   logic              fifo_full;
   logic              fifo_empty;

   assign req_ready = (credits != '0);
   assign st_acc    = req_valid & req_ready & req_we;
   assign ld_acc    = req_valid & req_ready & ~req_we;
   assign pop       = rsp_valid & rsp_ready;
   assign push      = s2.valid;
   assign push_data = s2.hit ? s2.data : mem_doutb;
   assign rsp_valid = ~fifo_empty;

   // Credits count free response slots, covering loads still in S1/S2 as well as buffered ones.
   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CRED_W'(RSP_DEPTH);
      end else if (ld_acc && !pop) begin
         credits <= credits - CRED_W'(1);
      end else if (pop && !ld_acc) begin
         credits <= credits + CRED_W'(1);
      end
   end

   // Port A write registers and the last-store register used for forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wea   <= 1'b0;
         mem_addra <= '0;
         mem_dina  <= '0;
         lv        <= 1'b0;
         laddr     <= '0;
         ldata     <= '0;
      end else begin
         mem_wea <= st_acc;
         if (st_acc) begin
            mem_addra <= req_addr;
            mem_dina  <= req_wdata;
            lv        <= 1'b1;
            laddr     <= req_addr;
            ldata     <= req_wdata;
         end
      end
   end

   // Two-stage load pipeline aligned with the one-cycle BRAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addrb <= '0;
         s1        <= '0;
         s2        <= '0;
      end else begin
         if (ld_acc) begin
            mem_addrb <= req_addr;
            s1.hit    <= lv && (laddr == req_addr);
            s1.data   <= ldata;
         end
         s1.valid <= ld_acc;
         s2       <= s1;
      end
   end

   dmem_rsp_fifo #(
      .DEPTH  (RSP_DEPTH),
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (rsp_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Credits bound occupancy, so a push never meets a full FIFO.
   assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural dual-port BRAM and an
// in-order response scoreboard.
module tb_dmem_access_ctrl;
   import dmem_pkg::*;

   localparam int ADDR_W = DMEM_ADDR_W;
   localparam int DATA_W = DMEM_DATA_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] mem_addra;
   logic [DATA_W-1:0] mem_dina;
   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addrb;
   logic [DATA_W-1:0] mem_doutb;

   logic [DATA_W-1:0] bram [2**ADDR_W];
   dmem_rsp_t         exp_q [$];
   int                n_tests = 0;
   int                n_fail  = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .mem_addra (mem_addra),
      .mem_dina  (mem_dina),
      .mem_wea   (mem_wea),
      .mem_addrb (mem_addrb),
      .mem_doutb (mem_doutb)
   );

   // Data_Mem model: port A write, port B synchronous read, both on clk.
   always @(posedge clk) begin
      if (mem_wea) bram[mem_addra] <= mem_dina;
      mem_doutb <= bram[mem_addrb];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Every handshaken response is checked against the oldest expected load.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         else check("rsp_data", rsp_rdata, exp_q.pop_front().rdata);
      end
   end

   function automatic dmem_req_t st(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      return '{we: 1'b1, addr: a, wdata: d};
   endfunction

   function automatic dmem_req_t ld(input logic [ADDR_W-1:0] a);
      return '{we: 1'b0, addr: a, wdata: '0};
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the request.
   task automatic issue(input dmem_req_t r, input logic [DATA_W-1:0] exp);
      int waited;
      waited    = 0;
      req_valid = 1'b1;
      req_we    = r.we;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
      else if (!r.we) exp_q.push_back('{rdata: exp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) bram[i] <= 64'(i);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wea",       64'(mem_wea),   64'd0);
      check("rst_addra",     64'(mem_addra), 64'd0);
      check("rst_dina",      mem_dina,       64'd0);
      check("rst_addrb",     64'(mem_addrb), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata,      64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Back-to-back loads of the preloaded image word[i] = i
      for (int i = 0; i < 5; i++) issue(ld(8'(i)), 64'(i));
      idle(8);
      check("t3_drain", 64'(exp_q.size()), 64'd0);

      // Single store: one write cycle, then a load two cycles after accept
      issue(st(8'd3, 64'hDEAD_BEEF_0000_0003), '0);
      req_valid = 1'b0;
      @(negedge clk);
      check("t1_wea_on", 64'(mem_wea),   64'd1);
      check("t1_addra",  64'(mem_addra), 64'd3);
      check("t1_dina",   mem_dina,       64'hDEAD_BEEF_0000_0003);
      @(negedge clk);
      check("t1_wea_off", 64'(mem_wea), 64'd0);
      check("t1_commit",  bram[3],      64'hDEAD_BEEF_0000_0003);
      idle(4);
      issue(ld(8'd3), 64'hDEAD_BEEF_0000_0003);
      req_valid = 1'b0;
      @(negedge clk);
      check("t1_addrb",  64'(mem_addrb), 64'd3);
      check("t1_lat_c0", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("t1_lat_c1", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("t1_lat_c2", 64'(rsp_valid), 64'd1);
      check("t1_rdata",  rsp_rdata,      64'hDEAD_BEEF_0000_0003);
      idle(3);

      // Store immediately followed by a same-address load
      issue(st(8'd5, 64'h55), '0);
      issue(ld(8'd5), 64'h55);
      idle(6);

      // Consumer stalled: the third load must wait for a free slot
      rsp_ready = 1'b0;
      issue(ld(8'd10), 64'd10);
      issue(ld(8'd11), 64'd11);
      fork
         issue(ld(8'd12), 64'd12);
         begin
            @(negedge clk);
            check("t4_ready_low", 64'(req_ready), 64'd0);
            repeat (3) @(negedge clk);
            check("t4_ready_held", 64'(req_ready), 64'd0);
            check("t4_rsp_valid",  64'(rsp_valid), 64'd1);
            check("t4_head",       rsp_rdata,      64'd10);
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      idle(8);
      check("t4_drain", 64'(exp_q.size()), 64'd0);

      // Top and bottom of the address space must not alias
      issue(st(8'd255, 64'd1), '0);
      issue(st(8'd0, 64'd2), '0);
      issue(ld(8'd255), 64'd1);
      issue(ld(8'd0), 64'd2);
      idle(8);
      check("t6_drain", 64'(exp_q.size()), 64'd0);

      // Reset with one response buffered and one load in flight
      rsp_ready = 1'b0;
      issue(ld(8'd20), 64'd20);
      issue(ld(8'd21), 64'd21);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("t5_pre_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t5_rst_valid", 64'(rsp_valid), 64'd0);
      check("t5_rst_rdata", rsp_rdata,      64'd0);
      check("t5_rst_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      idle(1);

      // Reset while a store is driving port A
      issue(st(8'd40, 64'h40), '0);
      req_valid = 1'b0;
      check("t5_pre_wea", 64'(mem_wea), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_wea",   64'(mem_wea),   64'd0);
      check("t5_rst_addra", 64'(mem_addra), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8);
      check("t5_no_stale",   64'(rsp_valid), 64'd0);
      check("t5_post_ready", 64'(req_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
